// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared APB widths, responder state encodings and default ID register value
package apb_bridge_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam logic [APB_DATA_W-1:0] DEF_ID_VALUE = 32'hA5B0_0001;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_t;
endpackage

// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB bus signals between bridge (master) and responder (slave)
interface apb_slave_regfile_if;
  logic [2:0] psel;
  logic penable;
  logic pwrite;
  logic [apb_bridge_pkg::APB_ADDR_W-1:0] paddr;
  logic [apb_bridge_pkg::APB_DATA_W-1:0] pwdata;
  logic [apb_bridge_pkg::APB_DATA_W-1:0] prdata;
  logic pready;
  logic pslverr;
  modport master(output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_regbank.sv
// apb_regbank: NUM_REGS x 32 register bank, sync write, async read, register 0 fixed to ID_VALUE
module apb_regbank
  import apb_bridge_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = DEF_ID_VALUE,
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  we,
  input  logic [IW-1:0]         waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [IW-1:0]         raddr,
  output logic [APB_DATA_W-1:0] rdata
);
  logic [APB_DATA_W-1:0] regs [NUM_REGS];
  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end
  assign rdata = raddr == '0 ? ID_VALUE : regs[raddr];
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB responder with programmable wait states serving a 32-bit register bank
module apb_slave_regfile
  import apb_bridge_pkg::*;
#(
  parameter int SLV_IDX = 0,
  parameter int NUM_REGS = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = DEF_ID_VALUE,
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input logic hclk,
  input logic hreset,
  apb_slave_regfile_if.slave bus
);
  apb_state_t state, nxt;
  logic [3:0] cnt, cnt_n;
  logic [APB_ADDR_W-1:0] addr, a;
  logic [APB_DATA_W-1:0] wdata, rdata;
  logic write, w, sel, setup, err, we, unused;
  logic [7:0] idx;
  assign sel = bus.psel[SLV_IDX];
  assign setup = sel & ~bus.penable;
  // Decode the live bus in IDLE (zero-wait entry to RESP) and the captured request otherwise
  assign a = state == ST_IDLE ? bus.paddr : addr;
  assign w = state == ST_IDLE ? bus.pwrite : write;
  assign idx = a[9:2];
  assign err = (a[1:0] != 2'b00) || ({1'b0, idx} >= 9'(NUM_REGS)) || (w && idx == 8'd0);
  assign we = state == ST_RESP && write && !bus.pslverr;
  assign unused = ^{a[31:10], bus.psel};
  always_comb begin
    nxt = state;
    cnt_n = cnt;
    case (state)
      ST_IDLE: if (setup) begin
        nxt = WAIT_STATES == 0 ? ST_RESP : ST_WAIT;
        cnt_n = 4'(WAIT_STATES);
      end
      ST_WAIT: if (!sel) nxt = ST_IDLE;
        else if (cnt == 4'd1) nxt = ST_RESP;
        else cnt_n = cnt - 4'd1;
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
    end
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr <= '0;
      write <= 1'b0;
      wdata <= '0;
      bus.prdata <= '0;
      bus.pready <= 1'b0;
      bus.pslverr <= 1'b0;
    end else begin
      if (state == ST_IDLE && setup) begin
        addr <= bus.paddr;
        write <= bus.pwrite;
        wdata <= bus.pwdata;
      end
      bus.pready <= nxt == ST_RESP;
      bus.pslverr <= nxt == ST_RESP && err;
      bus.prdata <= nxt != ST_RESP ? bus.prdata : err ? '0 : w ? bus.prdata : rdata;
    end
  end
  apb_regbank #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) u_bank (
    .hclk(hclk),
    .hreset(hreset),
    .we(we),
    .waddr(addr[IW+1:2]),
    .wdata(wdata),
    .raddr(idx[IW-1:0]),
    .rdata(rdata)
  );
endmodule
